nemu_packet_source: RTL and testbench
=====================================

// Module: nemu_packet_source
// PURPOSE
//  Per-port traffic source: takes the destination stream from the random number generator and injects packets
//  at a programmable Bernoulli rate. Packets are stamped (source, dest, timestamp, seq) and buffered in a small
//  FIFO, then presented to the network input port over a valid/ready handshake. One instance per emulated port.
// PARAMETERS
//  PORTS       8      number of network ports
//  PORT_BITS   3      $clog2(PORTS); width of source/dest fields
//  SOURCE_ID   0      this source's port number, 0..PORTS-1
//  LFSR_SEED   8'hA5  injection LFSR reset value; must be non-zero
//  FIFO_DEPTH  4      packet buffer entries; power of two, >=2
//  TIME_BITS   16     timestamp width
//  SEQ_BITS    8      sequence-number width
// PORTS
//  i_clk          in   1                   clock, all logic on rising edge
//  reset_n        in   1                   asynchronous active-low reset
//  i_enable       in   1                   1 = injection permitted this cycle
//  i_rate         in   8                   injection threshold; inject iff lfsr <= i_rate
//  i_dest         in   PORT_BITS           raw destination from the RNG, range 0..PORTS-2
//  o_pkt          out  packet_t            head-of-FIFO packet
//  o_pkt_valid    out  1                   o_pkt holds a valid packet
//  i_pkt_ready    in   1                   network accepts o_pkt this cycle
//  o_drop_count   out  16                  saturating count of injections lost to a full FIFO
// BEHAVIOUR
//  Reset (async assert, sync release): FIFO empty, o_pkt_valid=0, o_pkt='0, o_drop_count=0, timestamp=0,
//   seq=0, lfsr=LFSR_SEED. Reset mid-operation discards all buffered packets; no partial output.
//  LFSR: 8-bit Fibonacci, shift left, fb = r[7]^r[5]^r[4]^r[3]; steps every cycle regardless of i_enable;
//   period 255, never 0. Therefore i_rate=0 -> never inject, i_rate=255 -> inject every enabled cycle.
//  Inject event (cycle n): i_enable && (lfsr <= i_rate), evaluated on current lfsr.
//  Dest remap (removes self-traffic): dest = (i_dest >= SOURCE_ID) ? i_dest+1 : i_dest, PORT_BITS wide.
//   Result always in 0..PORTS-1 and != SOURCE_ID. i_dest > PORTS-2 is illegal input (assertion).
//  Packet fields: src=SOURCE_ID, dest=remapped, time=timestamp value in cycle n, seq=current seq.
//  Timestamp: free-running, +1 every cycle, wraps 2^TIME_BITS-1 -> 0.
//  Enqueue: on inject with FIFO not full, or full with a pop in the same cycle -> write; seq += 1 (wraps).
//  Drop: inject with FIFO full and no pop -> packet discarded, seq unchanged, o_drop_count += 1,
//   saturates at 16'hFFFF.
//  Latency: packet injected at edge n is visible on o_pkt/o_pkt_valid after edge n (no empty-bypass).
//  Handshake: pop when o_pkt_valid && i_pkt_ready. o_pkt stable while valid && !ready. Order strictly FIFO.
//  o_pkt_valid = FIFO non-empty; i_pkt_ready with FIFO empty is ignored.
//  Simultaneous push+pop on empty: push only. Push+pop on full: both, count stays FIFO_DEPTH.
// STRUCTURE
//  nemu_pkg: typedef struct packed {logic [PORT_BITS-1:0] src, dest; logic [TIME_BITS-1:0] time;
//   logic [SEQ_BITS-1:0] seq;} packet_t; LFSR tap constant; DROP_CNT_BITS=16.
//  Sub-module nemu_pkt_fifo (param WIDTH, DEPTH): sync FIFO, ptrs with extra wrap bit, push/pop/full/empty,
//   pop-on-full permits push. Top holds LFSR, remap, timestamp, seq, drop counter.
// TESTING
//  1 Reset: hold reset_n=0 3 cycles -> o_pkt_valid=0, o_drop_count=0; release -> lfsr sequence from 8'hA5.
//  2 Rate bounds: i_rate=0, i_enable=1, 300 cycles -> no packets; i_rate=255, ready=1 -> one packet per cycle,
//    seq 0,1,2,... consecutive, time fields increment by 1.
//  3 Remap, SOURCE_ID=3, PORTS=8: i_dest=2->dest 2; i_dest=3->4; i_dest=6->7; never dest 3.
//  4 Backpressure: rate=255, ready=0 -> valid after 1 cycle, FIFO fills in 4 cycles, then o_drop_count
//    +1 per cycle, seq frozen at 4; ready=1 -> packets seq 0..3 in order, o_pkt stable while stalled.
//  5 Full push+pop: FIFO full, ready=1 with inject -> no drop, occupancy stays 4.
//  6 Reset mid-stream with 3 packets buffered -> valid=0 next cycle; seq restarts at 0 after release.

Source files
------------

// File: rtl/nemu_pkg.sv
// Shared types and constants for the network-emulator packet source.
package nemu_pkg;

  localparam int PKT_PORT_BITS = 3;
  localparam int PKT_TIME_BITS = 16;
  localparam int PKT_SEQ_BITS  = 8;
  localparam int DROP_CNT_BITS = 16;

  // Feedback taps r[7], r[5], r[4], r[3] (x^8+x^6+x^5+x^4+1, maximal length)
  localparam logic [7:0] LFSR_TAPS = 8'hB8;

  typedef struct packed {
    logic [PKT_PORT_BITS-1:0] src;
    logic [PKT_PORT_BITS-1:0] dest;
    logic [PKT_TIME_BITS-1:0] ts;
    logic [PKT_SEQ_BITS-1:0]  seq;
  } packet_t;

  function automatic logic [7:0] lfsr_next(input logic [7:0] r);
    return {r[6:0], ^(r & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/nemu_packet_source_checker.sv
// Input legality checks for the packet source.
module nemu_packet_source_checker #(
  parameter int PORTS     = 8,
  parameter int PORT_BITS = 3
) (
  input logic                 i_clk,
  input logic                 reset_n,
  input logic [PORT_BITS-1:0] i_dest
);

  dest_in_range: assert property (@(posedge i_clk) disable iff (!reset_n)
    i_dest <= PORT_BITS'(PORTS - 2));

endmodule

// File: rtl/nemu_pkt_fifo.sv
// Synchronous packet FIFO; pointers carry an extra wrap bit to tell full from empty.
module nemu_pkt_fifo #(
  parameter int WIDTH = 30,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wr_data,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             push_en;
  logic             pop_en;

  // A pop frees the slot a same-cycle push needs when the FIFO is full
  always_comb begin
    empty   = (wr_ptr == rd_ptr);
    full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    pop_en  = pop && !empty;
    push_en = push && (!full || pop_en);
    rd_data = empty ? {WIDTH{1'b0}} : mem[rd_ptr[AW-1:0]];
  end

  // Pointer and storage update
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= {PW{1'b0}};
      rd_ptr <= {PW{1'b0}};
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= {WIDTH{1'b0}};
      end
    end else begin
      if (push_en) begin
        mem[wr_ptr[AW-1:0]] <= wr_data;
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (pop_en) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
    end
  end

endmodule

// File: rtl/nemu_packet_source.sv
// Per-port Bernoulli traffic source: stamps packets and buffers them ahead of a valid/ready port.
module nemu_packet_source
  import nemu_pkg::*;
#(
  parameter int         PORTS      = 8,
  parameter int         PORT_BITS  = 3,
  parameter int         SOURCE_ID  = 0,
  parameter logic [7:0] LFSR_SEED  = 8'hA5,
  parameter int         FIFO_DEPTH = 4,
  parameter int         TIME_BITS  = 16,
  parameter int         SEQ_BITS   = 8
) (
  input  logic                     i_clk,
  input  logic                     reset_n,
  input  logic                     i_enable,
  input  logic [7:0]               i_rate,
  input  logic [PORT_BITS-1:0]     i_dest,
  output packet_t                  o_pkt,
  output logic                     o_pkt_valid,
  input  logic                     i_pkt_ready,
  output logic [DROP_CNT_BITS-1:0] o_drop_count
);

  logic [7:0]               lfsr;
  logic [TIME_BITS-1:0]     timestamp;
  logic [SEQ_BITS-1:0]      seq;
  logic [DROP_CNT_BITS-1:0] drop_count;
  logic                     inject;
  logic                     pop;
  logic                     push;
  logic                     drop;
  logic                     full;
  logic                     empty;
  logic [PORT_BITS-1:0]     dest;
  packet_t                  new_pkt;

  // Inject decision, self-traffic remap and packet assembly
  always_comb begin
    inject = i_enable && (lfsr <= i_rate);
    pop    = !empty && i_pkt_ready;
    push   = inject && (!full || pop);
    drop   = inject && full && !pop;
    if (i_dest >= PORT_BITS'(SOURCE_ID)) begin
      dest = i_dest + PORT_BITS'(1);
    end else begin
      dest = i_dest;
    end
    new_pkt.src  = PKT_PORT_BITS'(SOURCE_ID);
    new_pkt.dest = dest;
    new_pkt.ts   = timestamp;
    new_pkt.seq  = seq;
  end

  // LFSR, free-running timestamp, sequence number and saturating drop counter
  always_ff @(posedge i_clk or negedge reset_n) begin
    if (!reset_n) begin
      lfsr       <= LFSR_SEED;
      timestamp  <= {TIME_BITS{1'b0}};
      seq        <= {SEQ_BITS{1'b0}};
      drop_count <= {DROP_CNT_BITS{1'b0}};
    end else begin
      lfsr      <= lfsr_next(lfsr);
      timestamp <= timestamp + TIME_BITS'(1);
      if (push) begin
        seq <= seq + SEQ_BITS'(1);
      end
      if (drop && (drop_count != {DROP_CNT_BITS{1'b1}})) begin
        drop_count <= drop_count + DROP_CNT_BITS'(1);
      end
    end
  end

  nemu_pkt_fifo #(
    .WIDTH($bits(packet_t)),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk    (i_clk),
    .rst_n  (reset_n),
    .push   (push),
    .pop    (pop),
    .wr_data(new_pkt),
    .rd_data(o_pkt),
    .full   (full),
    .empty  (empty)
  );

  nemu_packet_source_checker #(
    .PORTS    (PORTS),
    .PORT_BITS(PORT_BITS)
  ) u_checker (
    .i_clk  (i_clk),
    .reset_n(reset_n),
    .i_dest (i_dest)
  );

  assign o_pkt_valid  = !empty;
  assign o_drop_count = drop_count;

endmodule

// File: tb/tb_nemu_packet_source.sv
// Directed self-checking bench for nemu_packet_source (SOURCE_ID = 3).
module tb_nemu_packet_source;
  import nemu_pkg::*;

  logic        i_clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        i_enable = 1'b0;
  logic [7:0]  i_rate = 8'd0;
  logic [2:0]  i_dest = 3'd0;
  logic        i_pkt_ready = 1'b0;
  packet_t     o_pkt;
  logic        o_pkt_valid;
  logic [15:0] o_drop_count;

  int          tests = 0;
  int          fails = 0;
  logic [7:0]  m_lfsr = 8'hA5;
  logic [15:0] m_ts = 16'd0;

  always #5 i_clk = ~i_clk;

  nemu_packet_source #(
    .PORTS(8), .PORT_BITS(3), .SOURCE_ID(3), .LFSR_SEED(8'hA5),
    .FIFO_DEPTH(4), .TIME_BITS(16), .SEQ_BITS(8)
  ) dut (
    .i_clk       (i_clk),
    .reset_n     (reset_n),
    .i_enable    (i_enable),
    .i_rate      (i_rate),
    .i_dest      (i_dest),
    .o_pkt       (o_pkt),
    .o_pkt_valid (o_pkt_valid),
    .i_pkt_ready (i_pkt_ready),
    .o_drop_count(o_drop_count)
  );

  function automatic logic [7:0] step(input logic [7:0] r);
    return {r[6:0], r[7] ^ r[5] ^ r[4] ^ r[3]};
  endfunction

  // Hand-written remap table for SOURCE_ID = 3
  function automatic logic [2:0] remap3(input logic [2:0] d);
    case (d)
      3'd0:    return 3'd0;
      3'd1:    return 3'd1;
      3'd2:    return 3'd2;
      3'd3:    return 3'd4;
      3'd4:    return 3'd5;
      3'd5:    return 3'd6;
      3'd6:    return 3'd7;
      default: return 3'd3;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge i_clk);
    if (reset_n) begin
      m_lfsr = step(m_lfsr);
      m_ts   = m_ts + 16'd1;
    end
    @(negedge i_clk);
  endtask

  task automatic assert_reset();
    reset_n = 1'b0;
    m_lfsr  = 8'hA5;
    m_ts    = 16'd0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0]  seq_exp;
    logic [15:0] te;
    logic [15:0] te4;
    int          cnt;
    packet_t     head0;

    // Reset held for three cycles
    assert_reset();
    repeat (3) tick();
    chk("rst_valid", 64'(o_pkt_valid), 64'd0);
    chk("rst_drop", 64'(o_drop_count), 64'd0);
    chk("rst_pkt", 64'(o_pkt), 64'd0);
    reset_n = 1'b1;

    // LFSR sequence: rate equal to the expected value injects, one below does not
    i_enable = 1'b1;
    i_pkt_ready = 1'b1;
    seq_exp = 8'd0;
    for (int i = 0; i < 8; i++) begin
      i_dest = 3'(i % 7);
      if (i % 2 == 0) begin
        i_rate = m_lfsr;
        te = m_ts;
        tick();
        chk("lfsr_inj_valid", 64'(o_pkt_valid), 64'd1);
        chk("lfsr_inj_seq", 64'(o_pkt.seq), 64'(seq_exp));
        chk("lfsr_inj_ts", 64'(o_pkt.ts), 64'(te));
        chk("lfsr_inj_src", 64'(o_pkt.src), 64'd3);
        seq_exp = seq_exp + 8'd1;
      end else begin
        i_rate = m_lfsr - 8'd1;
        tick();
        chk("lfsr_noinj_valid", 64'(o_pkt_valid), 64'd0);
      end
    end

    // Rate 0 never injects
    i_rate = 8'd0;
    cnt = 0;
    repeat (300) begin
      tick();
      if (o_pkt_valid) cnt++;
    end
    chk("rate0_count", 64'(cnt), 64'd0);

    // Rate 255 injects every cycle; also sweeps the dest remap
    i_rate = 8'd255;
    for (int k = 0; k < 7; k++) begin
      i_dest = 3'(k);
      te = m_ts;
      tick();
      chk("r255_valid", 64'(o_pkt_valid), 64'd1);
      chk("r255_seq", 64'(o_pkt.seq), 64'(seq_exp));
      chk("r255_ts", 64'(o_pkt.ts), 64'(te));
      chk("remap_dest", 64'(o_pkt.dest), 64'(remap3(3'(k))));
      seq_exp = seq_exp + 8'd1;
    end

    // Backpressure from a fresh reset
    i_enable = 1'b0;
    assert_reset();
    tick();
    tick();
    reset_n = 1'b1;
    i_enable = 1'b1;
    i_rate = 8'd255;
    i_pkt_ready = 1'b0;
    i_dest = 3'd5;
    head0 = '{src: 3'd3, dest: 3'd6, ts: 16'd0, seq: 8'd0};
    tick();
    chk("bp_valid", 64'(o_pkt_valid), 64'd1);
    chk("bp_head", 64'(o_pkt), 64'(head0));
    repeat (3) tick();
    chk("bp_full_nodrop", 64'(o_drop_count), 64'd0);
    for (int d = 1; d <= 3; d++) begin
      tick();
      chk("bp_drop", 64'(o_drop_count), 64'(d));
      chk("bp_stable", 64'(o_pkt), 64'(head0));
    end

    // Push and pop together on a full FIFO
    i_pkt_ready = 1'b1;
    te4 = m_ts;
    tick();
    chk("fullpp_drop", 64'(o_drop_count), 64'd3);
    chk("fullpp_head", 64'(o_pkt.seq), 64'd1);
    i_enable = 1'b0;
    tick();
    chk("drain_seq2", 64'(o_pkt.seq), 64'd2);
    tick();
    chk("drain_seq3", 64'(o_pkt.seq), 64'd3);
    tick();
    chk("drain_seq4", 64'(o_pkt.seq), 64'd4);
    chk("drain_ts4", 64'(o_pkt.ts), 64'(te4));
    tick();
    chk("drain_empty", 64'(o_pkt_valid), 64'd0);

    // Reset with three packets buffered
    i_enable = 1'b1;
    i_pkt_ready = 1'b0;
    repeat (3) tick();
    chk("mid_valid", 64'(o_pkt_valid), 64'd1);
    assert_reset();
    #1;
    chk("mid_rst_valid", 64'(o_pkt_valid), 64'd0);
    chk("mid_rst_pkt", 64'(o_pkt), 64'd0);
    tick();
    reset_n = 1'b1;
    i_pkt_ready = 1'b1;
    tick();
    chk("post_valid", 64'(o_pkt_valid), 64'd1);
    chk("post_seq", 64'(o_pkt.seq), 64'd0);
    chk("post_ts", 64'(o_pkt.ts), 64'd0);
    chk("post_drop", 64'(o_drop_count), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
